// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle integer ops plus iterative multu/divu
// that produce the HI/LO register pair one bit per cycle.
//
// state | meaning
// IDLE  | ready for a new operation; single-cycle ops complete from here
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// DIV   | restoring divide in progress, one quotient bit per cycle
// DONE  | hi/lo just updated, result pulse presented; back to IDLE next
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] work_lo;   // multiplier being consumed / quotient
    logic [WIDTH-1:0] operand;   // multiplicand or divisor

    logic [WIDTH-1:0] dec_res;
    logic             dec_illegal;
    logic             dec_mul;
    logic             dec_div;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nxt;
    logic [WIDTH-1:0] div_lo_nxt;

    assign in_ready = (state == IDLE);

    // Decode the presented operation into a single-cycle result or a long-op start
    always_comb begin
        dec_res     = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (ALUOp)
            2'b00: dec_res = op_a + op_b;
            2'b01: dec_res = op_a - op_b;
            2'b10: begin
                case (funct)
                    6'b100000: dec_res = op_a + op_b;
                    6'b100010: dec_res = op_a - op_b;
                    6'b100100: dec_res = op_a & op_b;
                    6'b100101: dec_res = op_a | op_b;
                    6'b100110: dec_res = op_a ^ op_b;
                    6'b100111: dec_res = ~(op_a | op_b);
                    6'b101010: dec_res = WIDTH'($signed(op_a) < $signed(op_b));
                    6'b101011: dec_res = WIDTH'(op_a < op_b);
                    6'b011001: dec_mul = 1'b1;
                    6'b011011: dec_div = 1'b1;
                    6'b010000: dec_res = hi;
                    6'b010010: dec_res = lo;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // One iteration step of the multiply and of the divide
    always_comb begin
        mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};
        // A zero divisor always "fits", so the quotient fills with ones and the
        // remainder ends up holding the dividend shifted fully in.
        div_shift  = {work_hi, work_lo[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, operand});
        div_hi_nxt = div_ge ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
        div_lo_nxt = {work_lo[WIDTH-2:0], div_ge};
    end

    // Sequencer, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand   <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (dec_mul) begin
                            state   <= MUL;
                            work_hi <= '0;
                            work_lo <= op_b;
                            operand <= op_a;
                            cnt     <= CW'(WIDTH - 1);
                        end else if (dec_div) begin
                            state   <= DIV;
                            work_hi <= '0;
                            work_lo <= op_a;
                            operand <= op_b;
                            cnt     <= CW'(WIDTH - 1);
                        end else begin
                            out_valid <= 1'b1;
                            result    <= dec_res;
                            zero      <= (dec_res == '0);
                            illegal   <= dec_illegal;
                        end
                    end
                end
                MUL: begin
                    work_hi <= mul_hi_nxt;
                    work_lo <= mul_lo_nxt;
                    if (cnt == '0) begin
                        state     <= DONE;
                        hi        <= mul_hi_nxt;
                        lo        <= mul_lo_nxt;
                        out_valid <= 1'b1;
                        result    <= mul_lo_nxt;
                        zero      <= (mul_lo_nxt == '0);
                        illegal   <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV: begin
                    work_hi <= div_hi_nxt;
                    work_lo <= div_lo_nxt;
                    if (cnt == '0) begin
                        state     <= DONE;
                        hi        <= div_hi_nxt;
                        lo        <= div_lo_nxt;
                        out_valid <= 1'b1;
                        result    <= div_lo_nxt;
                        zero      <= (div_lo_nxt == '0);
                        illegal   <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the unit can accept an operation this cycle.
REQ-006 The block SHALL have port ALUOp, input, 2 bits: 00 add, 01 sub, 10 decode funct, 11 reserved.
REQ-007 The block SHALL have port funct, input, 6 bits: the R-type function field.
REQ-008 The block SHALL have ports op_a and op_b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-011 The block SHALL have port zero, output, 1 bit: result == 0, valid with out_valid.
REQ-012 The block SHALL have port illegal, output, 1 bit: an undecodable operation, valid with out_valid.
REQ-013 The block SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI/LO registers.

Function
REQ-014 An operation SHALL be accepted in a cycle where in_valid and in_ready are both 1; inputs SHALL be captured at that edge.
REQ-015 Decode SHALL be as follows:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- With ALUOp 10: funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 011001 multu, 011011 divu, 010000 mfhi, 010010 mflo.
REQ-016 Add and sub SHALL wrap modulo 2^WIDTH with no overflow flag; slt and sltu SHALL produce a zero-extended 1 or 0.
REQ-017 Single-cycle operations (all except multu and divu) SHALL assert out_valid exactly one cycle after acceptance, with result, zero and illegal registered.
REQ-018 ALUOp 11, or an unlisted funct with ALUOp 10, SHALL complete as a single-cycle operation with result 0, zero 1 and illegal 1, and SHALL leave hi/lo unchanged.
REQ-019 The state machine SHALL have states IDLE, MUL, DIV and DONE.
- IDLE -> MUL on accepted multu; IDLE -> DIV on accepted divu.
- MUL/DIV -> DONE after exactly WIDTH iteration cycles.
- DONE -> IDLE after one cycle.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 multu SHALL be an unsigned shift-add multiply of one bit per cycle; at DONE, {hi,lo} SHALL hold the 2*WIDTH product.
REQ-022 divu SHALL be an unsigned restoring divide of one bit per cycle; at DONE, lo SHALL hold the quotient and hi the remainder.
REQ-023 divu with op_b == 0 SHALL still take WIDTH cycles and then set lo = all ones and hi = op_a.
REQ-024 For multu and divu, out_valid SHALL pulse in the DONE cycle (WIDTH+1 cycles after acceptance), with result equal to the new lo.
REQ-025 hi and lo SHALL change only at DONE entry.
REQ-026 mfhi and mflo SHALL return the hi/lo value current at acceptance; back-to-back mflo after a completed multu SHALL see the new lo.
REQ-027 out_valid SHALL never be asserted for two consecutive cycles for the same operation.
REQ-028 result SHALL hold its value between pulses.
REQ-029 in_valid while in_ready is 0 SHALL be ignored; no queuing is performed.

Reset
REQ-030 When reset is 1 at a clock edge, the state SHALL go to IDLE, in_ready SHALL be 1, and out_valid, illegal, result, hi and lo SHALL be 0, with zero = 1.
REQ-031 Reset during MUL or DIV SHALL abort the operation with no out_valid pulse, and hi/lo SHALL be cleared.
REQ-032 in_valid in the reset cycle SHALL NOT be accepted.

Verification (WIDTH=32)
REQ-033 ALUOp 10, funct 101010, a=0xFFFFFFFF, b=1 -> out_valid next cycle, result=1; with funct 101011 -> result=0, zero=1.
REQ-034 multu a=0xFFFFFFFF, b=2 -> in_ready=0 for 33 cycles, out_valid at cycle 33, hi=0x00000001, lo=0xFFFFFFFE, result=0xFFFFFFFE.
REQ-035 divu a=100, b=7 -> lo=14, hi=2 at cycle 33; then mfhi -> result=2 next cycle.
REQ-036 divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234; ALUOp 11 -> illegal=1, result=0, hi/lo unchanged.
REQ-037 Reset asserted 10 cycles into multu -> no out_valid, hi=lo=0, in_ready=1 on the next cycle, and a following add 3+4 -> result=7.
REQ-038 in_valid held high throughout a divu -> exactly one divu result and no extra acceptances until in_ready returns to 1.
